pad_input_filter: RTL
=====================

# pad_input_filter

Parametrised multi-channel successor to the bare input pad buffer. Each channel carries an asynchronous pad input through an N-stage synchroniser and a per-channel stability filter (deglitch). It then presents a clean, registered level and single-cycle rise/fall strobes to core logic. It sits directly behind the input pad cells, between the pad ring and any consumer of off-chip control inputs (buttons, straps, slow handshake lines).

## Interface
- `WIDTH`, 1: number of independent channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel; legal range 2..4.
- `FILTER_CYCLES`, 4: consecutive cycles a new synchronised level must hold before it is accepted; legal range 1..65535.
- `RESET_VALUE`, 0: per-channel reset level, WIDTH bits; applies to synchroniser, `C` and history.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PAD`  in  WIDTH  raw pad inputs, asynchronous to `clk`.
- `bypass`  in  1  synchronous; 1 = filter disabled, `C` follows synchroniser output.
- `C`  out  WIDTH  filtered, registered level per channel.
- `rise`  out  WIDTH  1-cycle strobe, high in the cycle `C[i]` goes 0->1.
- `fall`  out  WIDTH  1-cycle strobe, high in the cycle `C[i]` goes 1->0.

## Operation
- Per channel i: synchroniser chain `sync[i][0..SYNC_STAGES-1]`, with `s[i]` = last stage. Also a counter `cnt[i]`, width clog2(FILTER_CYCLES+1).
- The reset clears every sync stage and `C` to `RESET_VALUE[i]`, `cnt` to 0, and `rise`/`fall` to 0. No strobe is generated on reset release.
- Filter, each cycle, when `bypass`=0:
  - If `s[i] == C[i]`: `cnt[i]` <= 0. Any partial count is discarded, so glitches shorter than FILTER_CYCLES are rejected.
  - Else, if `cnt[i] == FILTER_CYCLES-1`: `C[i]` <= `s[i]`, `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]`+1.
- When `bypass`=1: `C[i]` <= `s[i]` every cycle and `cnt[i]` <= 0.
- Toggling `bypass` mid-count: the count is dropped. On return to filtered mode, counting restarts from 0.
- Strobes are registered alongside `C`: `rise[i]` = new `C[i]` & ~old `C[i]`, `fall[i]` = ~new & old. Both are valid in the same cycle the new `C` value is first visible. They are never both high. Strobes fire in both filtered and bypass modes.
- Channels are fully independent, and simultaneous transitions on several channels are handled per channel.
- `rst` has priority over `bypass` and any in-progress count. A mid-filter reset returns `C` to `RESET_VALUE` with no strobe.
- The counter never exceeds FILTER_CYCLES-1, so there is no wrap.

## Timing
- Latency is measured from the first rising edge at which `PAD[i]` is sampled at a new stable level to `C[i]` changing:
  - filtered mode: SYNC_STAGES + FILTER_CYCLES edges;
  - bypass mode: SYNC_STAGES + 1 edges.
- With FILTER_CYCLES=1, the filtered latency equals bypass latency.
- Minimum accepted pulse width at `s`: FILTER_CYCLES cycles. Pulses of FILTER_CYCLES-1 cycles or fewer produce no change and no strobe.
- `PAD` setup relative to `clk` is not guaranteed. Metastability is resolved only by the synchroniser, and no logic reads any sync stage other than the last.
- All outputs are driven directly from flops, with no combinational path from `PAD` or `bypass` to any output.

## Test plan
- Reset: WIDTH=4, RESET_VALUE=4'b1010, hold `rst` for 3 cycles with `PAD`=4'b1010. Required: `C`=4'b1010 and `rise`=`fall`=0 during and after reset release.
- Clean edge: SYNC_STAGES=2, FILTER_CYCLES=4, `PAD[0]` 0->1 and held. Required: `C[0]`=1 exactly 6 edges after first sampling, `rise[0]`=1 for exactly that one cycle.
- Glitch reject: `PAD[1]` high for 3 cycles then low (FILTER_CYCLES=4). Required: `C[1]` stays 0, with no strobe. Repeat with 4 cycles high: `C[1]` pulses high for 4 cycles, with `rise` then `fall` strobes.
- Bypass: `bypass`=1, `PAD[2]` toggles every 2 cycles. Required: `C[2]` tracks the toggles 3 edges late, with a strobe on every transition.
- Simultaneous and mid-count reset: all channels go 0->1 together, giving 4-bit `rise`=4'b1111 in one cycle. Then drive `PAD`=0 and assert `rst` after 2 filter cycles. Required: `C`=RESET_VALUE with no `fall` strobe.
- Bypass switch mid-count: start a 0->1 transition, and after 2 filter cycles pulse `bypass` high for 1 cycle, then back to 0. Required: `C` updates during the bypass cycle, with exactly one `rise`.

Source files
------------

// File: rtl/pad_input_filter.sv
// pad_input_filter
//
// Multi-channel input conditioner that sits directly behind the input pad cells.
// Each channel carries an asynchronous pad level through a multi-flop synchroniser,
// then through a stability filter (deglitch). It then presents a clean registered
// level plus single-cycle rise/fall strobes to core logic.
//
// Parameters
//   WIDTH         number of independent channels
//   SYNC_STAGES   synchroniser flops per channel (legal 2..4)
//   FILTER_CYCLES consecutive cycles a new synchronised level must hold before it is
//                 accepted (legal 1..65535)
//   RESET_VALUE   per-channel reset level for synchroniser stages and C
//
// Ports
//   clk     sole clock, rising edge
//   rst     synchronous active-high reset; beats bypass and any in-progress count
//   PAD     raw pad inputs, asynchronous to clk
//   bypass  1 = filter disabled, C follows the synchroniser output every cycle
//   C       filtered, registered level per channel
//   rise    1-cycle strobe in the cycle C[i] first shows a 0->1 change
//   fall    1-cycle strobe in the cycle C[i] first shows a 1->0 change
//
// Every output comes straight from a flop. No combinational path runs from PAD or
// bypass to any output.

module pad_input_filter #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PAD,
  input  logic             bypass,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter sized to hold FILTER_CYCLES. It never runs past FILTER_CYCLES-1.
  localparam int unsigned     CntW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  // Stage 0 may go metastable. Only the last stage is read by any logic.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= PAD;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Stability filter
  // --------------------------------------------------------------------------
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] rise_q, fall_q;

  always_comb begin
    c_d = c_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      // Default clears the count. A level matching C, or a bypass cycle, discards
      // any partial count, so shorter glitches are dropped entirely.
      cnt_d[i] = '0;
      if (bypass) begin
        c_d[i] = s[i];
      end else if (s[i] != c_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          c_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      c_q    <= c_d;
      // Strobes are registered with C so they line up with the first cycle the new
      // level is visible.
      rise_q <= c_d & ~c_q;
      fall_q <= ~c_d & c_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign C    = c_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule
